quadra_horner: RTL

- Sequential quadratic evaluator, y = a*x^2 + b*x + c, computed by Horner's rule as ((a*x)+b)*x + c.
- Sits directly upstream of, and wraps, the existing signed fixed-point `mul` stage: one `mul` instance is reused for both products, and a T1_W-bit adder applies each coefficient.
- Operands and results are t1_fxd_t: sign, 3 integer bits, T1_W-4 fractional bits; 1.0 = 1<<(T1_W-4).
- valid/ready handshake on the input and output sides.

---
 rtl/quadra_horner.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/quadra_horner.sv
// Sequential quadratic evaluator y = a*x^2 + b*x + c by Horner's rule, reusing one mul stage.
// Optional build macro QUADRA_SAT_EN: saturate the two coefficient additions instead of wrapping.

// Signed fixed-point multiplier: sign + 3 integer bits + (T1_W-4) fraction bits.
// x2 is treated as a magnitude; its top bit is ignored. The product is truncated (floor).
module mul #(
  parameter int T1_W = 16
) (
  input  logic signed [T1_W-1:0] x1,
  input  logic        [T1_W-1:0] x2,
  output logic signed [T1_W-1:0] p
);

  logic signed [T1_W-1:0]   mag;
  logic signed [2*T1_W-1:0] full;
  logic                     unused_mul;

  assign mag  = {1'b0, x2[T1_W-2:0]};
  assign full = x1 * mag;
  assign p    = full[T1_W-4 +: T1_W];

  assign unused_mul = ^{x2[T1_W-1], full[T1_W-5:0], full[2*T1_W-1:2*T1_W-4]};

endmodule

module quadra_horner #(
  parameter int T1_W     = 16,
  parameter int PIPE_MUL = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [T1_W-1:0] a,
  input  logic signed [T1_W-1:0] b,
  input  logic signed [T1_W-1:0] c,
  input  logic signed [T1_W-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [T1_W-1:0] y,
  output logic                   out_err
);

  typedef logic signed [T1_W-1:0] t1_fxd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP1 = 3'd1,
    WAIT1 = 3'd2,
    STEP2 = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam bit PIPE = (PIPE_MUL != 0);

  function automatic t1_fxd_t add_coef(input t1_fxd_t p, input t1_fxd_t q);
`ifdef QUADRA_SAT_EN
    logic [T1_W:0] s;
    s = {p[T1_W-1], p} + {q[T1_W-1], q};
    if (s[T1_W] != s[T1_W-1])
      add_coef = s[T1_W] ? {1'b1, {(T1_W-1){1'b0}}} : {1'b0, {(T1_W-1){1'b1}}};
    else
      add_coef = s[T1_W-1:0];
`else
    add_coef = p + q;
`endif
  endfunction

  state_t  state, state_nxt;
  t1_fxd_t acc, x_q, b_q, c_q, prod, prod_q, addend, prod_sel, sum;
  logic    err_q;
  logic    accept;

  mul #(.T1_W(T1_W)) u_mul (
    .x1 (acc),
    .x2 (x_q),
    .p  (prod)
  );

  // Addend follows the Horner step: b after the first product, c after the second.
  always_comb begin
    addend   = c_q;
    if (state == STEP1 || state == WAIT1)
      addend = b_q;
    prod_sel = PIPE ? prod_q : prod;
    sum      = add_coef(prod_sel, addend);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || (state == DONE && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (in_valid) state_nxt = STEP1;
      STEP1:   state_nxt = PIPE ? WAIT1 : STEP2;
      WAIT1:   state_nxt = STEP2;
      STEP2:   state_nxt = PIPE ? WAIT2 : DONE;
      WAIT2:   state_nxt = DONE;
      DONE: begin
        if (out_ready)
          state_nxt = in_valid ? STEP1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch and Horner accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      x_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      err_q  <= 1'b0;
      prod_q <= '0;
    end else if (accept) begin
      acc   <= a;
      x_q   <= x;
      b_q   <= b;
      c_q   <= c;
      err_q <= x[T1_W-1];
    end else begin
      case (state)
        STEP1, STEP2: begin
          if (PIPE) prod_q <= prod;
          else      acc    <= sum;
        end
        WAIT1, WAIT2: acc <= sum;
        default: ;
      endcase
    end
  end

  // Result register: loaded once on entry to DONE, held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (state != DONE && state_nxt == DONE) begin
        y       <= sum;
        out_err <= err_q;
      end
    end
  end

endmodule
